// File: rtl/fatori_mon_voter_lanes.sv
// fatori_mon_voter_lanes
// Registered, lane-split M-of-N voter for replicated bundles.
// Each W-bit bundle is cut into LANES slices that are voted independently
// among the active (non-isolated) replicas. A per-replica strike counter
// isolates replicas that keep disagreeing, and the quorum follows the active
// set. Saturating min/maj error counters feed the monitor status registers.
//
// Optional feature, macro FATORI_VOTER_HOLD_EN:
//   defined   - a lane without a winner outputs its last-good slice and
//               scrub_occurred_o reports the substitution.
//   undefined - a lane without a winner outputs 0; scrub_occurred_o is 0.
module fatori_mon_voter_lanes #(
    parameter int W        = 32,
    parameter int N        = 3,
    parameter int LANES    = 1,
    parameter int M        = 0,
    parameter int MISS_THR = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [N-1:0][W-1:0]  replicas_i,
    input  logic                 clr_i,
    output logic                 valid_o,
    output logic [W-1:0]         y_o,
    output logic                 min_err_o,
    output logic                 maj_err_o,
    output logic [LANES-1:0]     lane_maj_err_o,
    output logic [N-1:0]         replica_fault_o,
    output logic [N-1:0]         isolated_o,
    output logic [CNT_W-1:0]     min_cnt_o,
    output logic [CNT_W-1:0]     maj_cnt_o,
    output logic                 scrub_occurred_o
);

    localparam int LW = W / LANES;
    localparam int SW = $clog2(MISS_THR + 1);
    localparam logic [SW-1:0] STRIKE_MAX = SW'(MISS_THR);

    // Registered state
    logic                 valid_reg;
    logic [W-1:0]         y_reg;
    logic                 min_err_reg;
    logic                 maj_err_reg;
    logic [LANES-1:0]     lane_maj_err_reg;
    logic [N-1:0]         replica_fault_reg;
    logic [N-1:0]         isolated_reg;
    logic [SW-1:0]        strike_reg [N];
    logic [CNT_W-1:0]     min_cnt_reg;
    logic [CNT_W-1:0]     maj_cnt_reg;

    // Vote results (combinational, from current inputs and isolation mask)
    logic [N-1:0]         active;
    int                   active_cnt;
    int                   quorum;
    logic [LANES-1:0]     lane_win;
    logic [N-1:0]         lane_dis [LANES];
    logic [W-1:0]         y_vote;
    logic [N-1:0]         fault_vec;
    logic                 maj_vote;
    logic                 min_vote;
    logic                 any_win;

    // Strike / isolation next state
    logic [SW-1:0]        strike_next [N];
    logic [N-1:0]         iso_next;
    int                   a_run;

    assign active = ~isolated_reg;

    // Active replica count and the quorum that follows it
    always_comb begin
        active_cnt = 0;
        for (int r = 0; r < N; r++) begin
            active_cnt = active_cnt + (active[r] ? 1 : 0);
        end
        quorum = (M > 0) ? M : (active_cnt / 2 + 1);
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LW-1:0] cand_val;
            logic          found;
            logic          clash;
            logic [N-1:0]  dis;
            int            match_cnt;

            // A value reaching quorum becomes the candidate; any other value
            // that also reaches quorum makes the lane ambiguous.
            always_comb begin
                found     = 1'b0;
                clash     = 1'b0;
                cand_val  = '0;
                dis       = '0;
                match_cnt = 0;
                for (int r = 0; r < N; r++) begin
                    match_cnt = 0;
                    for (int s = 0; s < N; s++) begin
                        if (active[s] &&
                            replicas_i[s][gi*LW +: LW] == replicas_i[r][gi*LW +: LW]) begin
                            match_cnt = match_cnt + 1;
                        end
                    end
                    if (active[r] && match_cnt >= quorum) begin
                        if (!found) begin
                            found    = 1'b1;
                            cand_val = replicas_i[r][gi*LW +: LW];
                        end else if (replicas_i[r][gi*LW +: LW] != cand_val) begin
                            clash = 1'b1;
                        end
                    end
                end
                for (int r = 0; r < N; r++) begin
                    dis[r] = found && !clash && active[r] &&
                             (replicas_i[r][gi*LW +: LW] != cand_val);
                end
            end

            assign lane_win[gi] = found && !clash;
            assign lane_dis[gi] = dis;
`ifdef FATORI_VOTER_HOLD_EN
            logic [LW-1:0] last_good_reg;

            // Remember the most recent winner of this lane; only reset clears it
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    last_good_reg <= '0;
                end else if (valid_i && lane_win[gi]) begin
                    last_good_reg <= cand_val;
                end
            end

            assign y_vote[gi*LW +: LW] = lane_win[gi] ? cand_val : last_good_reg;
`else
            assign y_vote[gi*LW +: LW] = lane_win[gi] ? cand_val : '0;
`endif
        end
    endgenerate

    // Merge per-lane results into bundle-level flags
    always_comb begin
        fault_vec = '0;
        for (int l = 0; l < LANES; l++) begin
            fault_vec = fault_vec | lane_dis[l];
        end
        maj_vote = ~&lane_win;
        any_win  = |lane_win;
        min_vote = !maj_vote && (|fault_vec);
    end

    // Strike update, then ascending-index isolation that never drops A below 2
    always_comb begin
        iso_next = isolated_reg;
        a_run    = active_cnt;
        for (int r = 0; r < N; r++) begin
            strike_next[r] = strike_reg[r];
            if (!isolated_reg[r]) begin
                if (fault_vec[r]) begin
                    if (strike_reg[r] != STRIKE_MAX) begin
                        strike_next[r] = strike_reg[r] + 1'b1;
                    end
                end else if (any_win) begin
                    strike_next[r] = '0;
                end
            end
        end
        for (int r = 0; r < N; r++) begin
            if (!isolated_reg[r] && fault_vec[r] &&
                strike_next[r] == STRIKE_MAX && a_run > 2) begin
                iso_next[r] = 1'b1;
                a_run       = a_run - 1;
            end
        end
    end

    // Vote outputs, strike/isolation tracking and event counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg         <= 1'b0;
            y_reg             <= '0;
            min_err_reg       <= 1'b0;
            maj_err_reg       <= 1'b0;
            lane_maj_err_reg  <= '0;
            replica_fault_reg <= '0;
            isolated_reg      <= '0;
            min_cnt_reg       <= '0;
            maj_cnt_reg       <= '0;
            for (int r = 0; r < N; r++) begin
                strike_reg[r] <= '0;
            end
        end else begin
            valid_reg <= valid_i;
            if (valid_i) begin
                y_reg             <= y_vote;
                min_err_reg       <= min_vote;
                maj_err_reg       <= maj_vote;
                lane_maj_err_reg  <= ~lane_win;
                replica_fault_reg <= fault_vec;
            end
            if (clr_i) begin
                isolated_reg <= '0;
                min_cnt_reg  <= '0;
                maj_cnt_reg  <= '0;
                for (int r = 0; r < N; r++) begin
                    strike_reg[r] <= '0;
                end
            end else if (valid_i) begin
                isolated_reg <= iso_next;
                for (int r = 0; r < N; r++) begin
                    strike_reg[r] <= strike_next[r];
                end
                if (min_vote && min_cnt_reg != '1) begin
                    min_cnt_reg <= min_cnt_reg + 1'b1;
                end
                if (maj_vote && maj_cnt_reg != '1) begin
                    maj_cnt_reg <= maj_cnt_reg + 1'b1;
                end
            end
        end
    end

`ifdef FATORI_VOTER_HOLD_EN
    logic scrub_reg;

    // Any no-winner lane in a vote means a last-good slice was substituted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scrub_reg <= 1'b0;
        end else if (valid_i) begin
            scrub_reg <= maj_vote;
        end
    end

    assign scrub_occurred_o = scrub_reg;
`else
    assign scrub_occurred_o = 1'b0;
`endif

    assign valid_o         = valid_reg;
    assign y_o             = y_reg;
    assign min_err_o       = min_err_reg;
    assign maj_err_o       = maj_err_reg;
    assign lane_maj_err_o  = lane_maj_err_reg;
    assign replica_fault_o = replica_fault_reg;
    assign isolated_o      = isolated_reg;
    assign min_cnt_o       = min_cnt_reg;
    assign maj_cnt_o       = maj_cnt_reg;

endmodule

// File: tb/tb_fatori_mon_voter_lanes.sv
// tb_fatori_mon_voter_lanes
// Drives directed and random votes into a 3-replica, 4-lane voter and compares
// every output, every cycle, against a distinct-value counting model.
module tb_fatori_mon_voter_lanes;

    localparam int W     = 32;
    localparam int N     = 3;
    localparam int LANES = 4;
    localparam int M     = 0;
    localparam int THR   = 4;
    localparam int CNT_W = 3;
    localparam int LW    = W / LANES;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 valid;
    logic                 clr;
    logic [N-1:0][W-1:0]  reps;
    logic                 valid_o;
    logic [W-1:0]         y_o;
    logic                 min_err_o;
    logic                 maj_err_o;
    logic [LANES-1:0]     lane_maj_err_o;
    logic [N-1:0]         replica_fault_o;
    logic [N-1:0]         isolated_o;
    logic [CNT_W-1:0]     min_cnt_o;
    logic [CNT_W-1:0]     maj_cnt_o;
    logic                 scrub_occurred_o;

    always #5 clk = ~clk;

    fatori_mon_voter_lanes #(
        .W(W), .N(N), .LANES(LANES), .M(M), .MISS_THR(THR), .CNT_W(CNT_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .valid_i          (valid),
        .replicas_i       (reps),
        .clr_i            (clr),
        .valid_o          (valid_o),
        .y_o              (y_o),
        .min_err_o        (min_err_o),
        .maj_err_o        (maj_err_o),
        .lane_maj_err_o   (lane_maj_err_o),
        .replica_fault_o  (replica_fault_o),
        .isolated_o       (isolated_o),
        .min_cnt_o        (min_cnt_o),
        .maj_cnt_o        (maj_cnt_o),
        .scrub_occurred_o (scrub_occurred_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit               m_valid;
    logic [W-1:0]     m_y;
    bit               m_min, m_maj, m_scrub;
    logic [LANES-1:0] m_lane;
    logic [N-1:0]     m_fault, m_iso;
    int               m_strike [N];
    int               m_minc, m_majc;
    logic [LW-1:0]    m_last [LANES];

    function automatic int count_active();
        int c = 0;
        for (int r = 0; r < N; r++) if (!m_iso[r]) c++;
        return c;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_y = '0; m_min = 0; m_maj = 0; m_scrub = 0;
        m_lane = '0; m_fault = '0; m_iso = '0; m_minc = 0; m_majc = 0;
        for (int r = 0; r < N; r++) m_strike[r] = 0;
        for (int l = 0; l < LANES; l++) m_last[l] = '0;
    endtask

    task automatic model_step();
        logic [LW-1:0] vals [$];
        int            cnts [$];
        logic [LW-1:0] sl, wv;
        logic [N-1:0]  f;
        bit            anywin, maj;
        int            q, idx, nq;
        if (rst) begin
            model_reset();
            return;
        end
        m_valid = valid;
        if (!valid) begin
            if (clr) begin
                m_iso = '0; m_minc = 0; m_majc = 0;
                for (int r = 0; r < N; r++) m_strike[r] = 0;
            end
            return;
        end
        q = (M > 0) ? M : count_active() / 2 + 1;
        f = '0; anywin = 0; maj = 0;
        for (int l = 0; l < LANES; l++) begin
            vals.delete(); cnts.delete();
            for (int r = 0; r < N; r++) begin
                if (m_iso[r]) continue;
                sl = reps[r][l*LW +: LW];
                idx = -1;
                foreach (vals[k]) if (vals[k] == sl) idx = k;
                if (idx < 0) begin vals.push_back(sl); cnts.push_back(1); end
                else cnts[idx]++;
            end
            nq = 0; wv = '0;
            foreach (cnts[k]) if (cnts[k] >= q) begin nq++; wv = vals[k]; end
            if (nq == 1) begin
                anywin = 1;
                m_lane[l] = 1'b0;
                m_y[l*LW +: LW] = wv;
                m_last[l] = wv;
                for (int r = 0; r < N; r++)
                    if (!m_iso[r] && reps[r][l*LW +: LW] != wv) f[r] = 1'b1;
            end else begin
                maj = 1;
                m_lane[l] = 1'b1;
`ifdef FATORI_VOTER_HOLD_EN
                m_y[l*LW +: LW] = m_last[l];
`else
                m_y[l*LW +: LW] = '0;
`endif
            end
        end
        m_fault = f;
        m_maj   = maj;
        m_min   = !maj && (f != '0);
`ifdef FATORI_VOTER_HOLD_EN
        m_scrub = maj;
`endif
        if (clr) begin
            m_iso = '0; m_minc = 0; m_majc = 0;
            for (int r = 0; r < N; r++) m_strike[r] = 0;
            return;
        end
        for (int r = 0; r < N; r++) begin
            if (m_iso[r]) continue;
            if (f[r]) m_strike[r] = (m_strike[r] < THR) ? m_strike[r] + 1 : THR;
            else if (anywin) m_strike[r] = 0;
        end
        for (int r = 0; r < N; r++)
            if (!m_iso[r] && f[r] && m_strike[r] == THR && count_active() - 1 >= 2)
                m_iso[r] = 1'b1;
        if (m_min && m_minc < CMAX) m_minc++;
        if (m_maj && m_majc < CMAX) m_majc++;
    endtask

    task automatic compare_all();
        check("valid_o", valid_o, m_valid);
        check("y_o", y_o, m_y);
        check("min_err_o", min_err_o, m_min);
        check("maj_err_o", maj_err_o, m_maj);
        check("lane_maj_err_o", lane_maj_err_o, m_lane);
        check("replica_fault_o", replica_fault_o, m_fault);
        check("isolated_o", isolated_o, m_iso);
        check("min_cnt_o", min_cnt_o, m_minc);
        check("maj_cnt_o", maj_cnt_o, m_majc);
        check("scrub_occurred_o", scrub_occurred_o, m_scrub);
    endtask

    task automatic step(input bit v, input bit c, input bit r);
        valid = v; clr = c; rst = r;
        @(posedge clk);
        #1;
        model_step();
        compare_all();
        if (v && !r)
            $display("vote t=%0t clr=%0b y=%h min=%0b maj=%0b lanes=%b fault=%b iso=%b cnt=%0d/%0d",
                     $time, c, y_o, min_err_o, maj_err_o, lane_maj_err_o,
                     replica_fault_o, isolated_o, min_cnt_o, maj_cnt_o);
    endtask

    task automatic set_all(input logic [W-1:0] v);
        for (int r = 0; r < N; r++) reps[r] = v;
    endtask

    // Random bundle: mostly agreeing, with lane corruptions and occasional chaos
    task automatic gen_reps(input int bad_r);
        logic [W-1:0] base;
        int           l;
        base = $urandom;
        set_all(base);
        if ($urandom_range(0, 19) == 0) begin
            for (int r = 0; r < N; r++) reps[r] = $urandom;
            return;
        end
        for (int r = 0; r < N; r++) begin
            if (r == bad_r || $urandom_range(0, 6) == 0) begin
                l = $urandom_range(0, LANES - 1);
                reps[r][l*LW +: LW] = reps[r][l*LW +: LW] ^ LW'($urandom_range(1, 255));
            end
        end
    endtask

    initial begin
        int bad_r;
        rst = 1'b1; valid = 1'b0; clr = 1'b0; reps = '0;
        model_reset();
        step(0, 0, 1);
        step(1, 1, 1);
        // Clean agreement
        set_all(32'hA5A5_0000);
        step(1, 0, 0);
        step(0, 0, 0);
        // Replica 2 byte 1 flipped: minority error
        reps[2] = 32'hA5A5_0000 ^ 32'h0000_FF00;
        step(1, 0, 0);
        // Replica 1 corrupt for four votes: isolated after the fourth
        for (int i = 0; i < 4; i++) begin
            set_all(32'h1234_5678);
            reps[1] = 32'h1234_5678 ^ 32'h0000_0011;
            step(1, 0, 0);
        end
        // Two active replicas disagree: no quorum
        reps[0] = 32'h1111_1111; reps[1] = 32'h3333_3333; reps[2] = 32'h2222_2222;
        step(1, 0, 0);
        // Clear together with a vote where replica 0 is faulty
        set_all(32'hCAFE_BABE);
        reps[0] = 32'hCAFE_BA00;
        step(1, 1, 0);
        step(0, 0, 0);
        // All three differ
        set_all(32'h0F0F_0F0F);
        step(1, 0, 0);
        reps[0] = 32'h0101_0101; reps[1] = 32'h0202_0202; reps[2] = 32'h0303_0303;
        step(1, 0, 0);
        // Drive maj_err votes past counter saturation
        for (int i = 0; i < CMAX + 2; i++) begin
            reps[0] = $urandom; reps[1] = $urandom; reps[2] = $urandom;
            step(1, 0, 0);
        end
        // Reset mid-stream
        step(1, 0, 1);
        // Random traffic with phases of a persistently faulty replica
        bad_r = N;
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) bad_r = $urandom_range(0, N);
            gen_reps(bad_r);
            step($urandom_range(0, 9) < 8,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 249) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
